psum_mem_ctrl: RTL and testbench

//  Responder side of the memctrl0 partial-sum memory interface driven by psum_accum_ctrl

---
 rtl/psum_mem_ctrl_pkg.sv | 17 +
 rtl/psum_mem_ctrl_if.sv | 25 ++
 rtl/psum_mem_ctrl_sdp_ram.sv | 28 ++
 rtl/psum_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_psum_mem_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/psum_mem_ctrl_pkg.sv
// Shared defaults, FSM encoding and error-bit positions for the partial-sum memory controller.
package psum_mem_ctrl_pkg;

    localparam int PSUM_ADDR_WIDTH = 32;
    localparam int PSUM_DATA_WIDTH = 32;
    localparam int PSUM_DEPTH_LOG2 = 10;
    localparam int PSUM_RD_LATENCY = 2;

    typedef enum logic {
        PMC_IDLE  = 1'b0,
        PMC_CLEAR = 1'b1
    } pmc_state_t;

    localparam int ERR_RANGE_BIT = 0;
    localparam int ERR_BUSY_BIT  = 1;

endpackage

// File: rtl/psum_mem_ctrl_if.sv
// memctrl0 write/read bus between psum_accum_ctrl (master) and the buffer (slave).
interface psum_mem_ctrl_if
    import psum_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] wadd;
    logic                  wren;
    logic [DATA_WIDTH-1:0] idat;
    logic [ADDR_WIDTH-1:0] radd;
    logic                  rden;
    logic [DATA_WIDTH-1:0] odat;
    logic                  oval;

    modport master (
        output wadd, wren, idat, radd, rden,
        input  odat, oval
    );

    modport slave (
        input  wadd, wren, idat, radd, rden,
        output odat, oval
    );
endinterface

// File: rtl/psum_mem_ctrl_sdp_ram.sv
// Simple dual-port buffer: one write port, one registered read port, no reset (BRAM friendly).
module psum_mem_ctrl_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read returns the pre-write word on a collision; the caller bypasses.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/psum_mem_ctrl.sv
// Partial-sum buffer responder: write-first forwarding, fixed-latency read pipe,
// whole-buffer clear engine and sticky error flags.
module psum_mem_ctrl
    import psum_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int DEPTH_LOG2 = PSUM_DEPTH_LOG2,
    parameter int RD_LATENCY = PSUM_RD_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    psum_mem_ctrl_if.slave       memctrl0,
    input  logic                 i_clr,
    output logic                 o_busy,
    output logic [1:0]           o_err
);
    localparam int STAGES = RD_LATENCY - 1;

    pmc_state_t            state_reg, state_next;
    logic [DEPTH_LOG2:0]   cnt_reg, cnt_next;
    logic [1:0]            err_reg, err_next;
    logic                  clr_active;

    logic                  wr_in_range, rd_in_range, host_wr, host_rd, bypass;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    logic                  v0_reg, oor0_reg, byp0_reg;
    logic [DATA_WIDTH-1:0] bypd0_reg, s0_data, out_d;
    logic                  out_v;

    assign wr_in_range = (memctrl0.wadd[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    assign rd_in_range = (memctrl0.radd[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    assign host_wr     = memctrl0.wren && !clr_active && wr_in_range;
    assign host_rd     = memctrl0.rden && !clr_active;
    assign bypass      = host_wr && (memctrl0.wadd == memctrl0.radd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= PMC_IDLE;
            cnt_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            PMC_IDLE: begin
                if ((memctrl0.wren && !wr_in_range) || (memctrl0.rden && !rd_in_range)) begin
                    err_next[ERR_RANGE_BIT] = 1'b1;
                end
                if (i_clr) begin
                    state_next = PMC_CLEAR;
                    cnt_next   = '0;
                    err_next   = '0;
                end
            end
            PMC_CLEAR: begin
                cnt_next = cnt_reg + {{DEPTH_LOG2{1'b0}}, 1'b1};
                if (memctrl0.wren || memctrl0.rden) begin
                    err_next[ERR_BUSY_BIT] = 1'b1;
                end
                // MSB rises right after the last index has been written.
                if (cnt_next[DEPTH_LOG2]) begin
                    state_next = PMC_IDLE;
                end
            end
            default: state_next = PMC_IDLE;
        endcase
    end

    always_comb begin
        clr_active = (state_reg == PMC_CLEAR);
        o_busy     = clr_active;
    end

    assign o_err = err_reg;

    assign ram_we    = clr_active || host_wr;
    assign ram_waddr = clr_active ? cnt_reg[DEPTH_LOG2-1:0] : memctrl0.wadd[DEPTH_LOG2-1:0];
    assign ram_wdata = clr_active ? '0 : memctrl0.idat;

    psum_mem_ctrl_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (host_rd),
        .raddr (memctrl0.radd[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    // Side information travelling alongside the RAM's own read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_reg    <= 1'b0;
            oor0_reg  <= 1'b0;
            byp0_reg  <= 1'b0;
            bypd0_reg <= '0;
        end else begin
            v0_reg    <= host_rd;
            oor0_reg  <= !rd_in_range;
            byp0_reg  <= bypass;
            bypd0_reg <= memctrl0.idat;
        end
    end

    assign s0_data = oor0_reg ? '0 : (byp0_reg ? bypd0_reg : ram_rdata);

    generate
        if (STAGES == 0) begin : g_direct
            assign out_v = v0_reg;
            assign out_d = s0_data;
        end else begin : g_shift
            logic                  pipe_v [1:STAGES];
            logic [DATA_WIDTH-1:0] pipe_d [1:STAGES];
            for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
                if (gi == 1) begin : g_first
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            pipe_v[gi] <= 1'b0;
                            pipe_d[gi] <= '0;
                        end else begin
                            pipe_v[gi] <= v0_reg;
                            pipe_d[gi] <= s0_data;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            pipe_v[gi] <= 1'b0;
                            pipe_d[gi] <= '0;
                        end else begin
                            pipe_v[gi] <= pipe_v[gi-1];
                            pipe_d[gi] <= pipe_d[gi-1];
                        end
                    end
                end
            end
            assign out_v = pipe_v[STAGES];
            assign out_d = pipe_d[STAGES];
        end
    endgenerate

    assign memctrl0.oval = out_v;
    assign memctrl0.odat = out_v ? out_d : '0;
endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Directed plus randomized bench for psum_mem_ctrl against a word-array/queue reference model.
module tb_psum_mem_ctrl;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DL    = 10;
    localparam int RDL   = 2;
    localparam int DEPTH = 1 << DL;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_clr;
    logic       o_busy;
    logic [1:0] o_err;

    psum_mem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    psum_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .RD_LATENCY (RDL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memctrl0 (bus),
        .i_clr    (i_clr),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int clr_left  = 0;
    int oval_seen = 0;
    int busy_seen = 0;

    logic [DW-1:0] ref_mem   [0:DEPTH-1];
    bit            ref_known [0:DEPTH-1];
    logic [1:0]    ref_err = 2'b00;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        bit            known;
    } exp_t;
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit re, input logic [AW-1:0] ra, input bit clr);
        bus.wren = we;
        bus.wadd = wa;
        bus.idat = wd;
        bus.rden = re;
        bus.radd = ra;
        i_clr    = clr;
    endtask

    // Applies the behavioural rules to the inputs sampled at one rising edge.
    task automatic model_edge();
        exp_t e;
        cyc++;
        if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left]   = '0;
            ref_known[DEPTH - clr_left] = 1'b1;
            if (bus.wren || bus.rden) ref_err[1] = 1'b1;
            clr_left--;
        end else begin
            if (bus.wren) begin
                if (bus.wadd >= DEPTH) ref_err[0] = 1'b1;
                else begin
                    ref_mem[bus.wadd[DL-1:0]]   = bus.idat;
                    ref_known[bus.wadd[DL-1:0]] = 1'b1;
                end
            end
            if (bus.rden) begin
                // Data is on the bus for the consumer to sample at edge cyc+RDL.
                e.due = cyc + RDL - 1;
                if (bus.radd >= DEPTH) begin
                    e.d = '0;
                    e.known = 1'b1;
                    ref_err[0] = 1'b1;
                end else begin
                    e.d = ref_mem[bus.radd[DL-1:0]];
                    e.known = ref_known[bus.radd[DL-1:0]];
                end
                exp_q.push_back(e);
            end
            if (i_clr) begin
                ref_err  = 2'b00;
                clr_left = DEPTH;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (bus.oval === 1'b1) oval_seen++;
        if (o_busy === 1'b1) busy_seen++;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("oval", {63'd0, bus.oval}, 64'd1);
            if (e.known) chk("odat", {32'd0, bus.odat}, {32'd0, e.d});
        end else begin
            chk("oval", {63'd0, bus.oval}, 64'd0);
        end
        chk("o_busy", {63'd0, o_busy}, {63'd0, (clr_left > 0)});
        chk("o_err", {62'd0, o_err}, {62'd0, ref_err});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_idle(input int n);
        drive(0, '0, '0, 0, '0, 0);
        repeat (n) cycle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        rst = 1'b0;
        drive(0, '0, '0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oval", {63'd0, bus.oval}, 64'd0);
        chk("reset_odat", {32'd0, bus.odat}, 64'd0);
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_err", {62'd0, o_err}, 64'd0);
        $display("reset: outputs checked idle");
        rst = 1'b1;

        busy_seen = 0;
        drive(0, '0, '0, 0, '0, 1);
        cycle();
        run_idle(DEPTH + 6);
        chk("init_clear_busy_cycles", 64'(busy_seen), 64'(DEPTH));
        $display("init clear: busy for %0d cycles", busy_seen);

        drive(1, 32'd5, 32'h0000_00AA, 0, '0, 0); cycle();
        run_idle(1);
        drive(0, '0, '0, 1, 32'd5, 0); cycle();
        run_idle(4);
        $display("case1: write 0xAA to 5, read back");

        drive(1, 32'd7, 32'h11, 1, 32'd7, 0); cycle();
        drive(1, 32'd7, 32'h22, 0, '0, 0); cycle();
        run_idle(4);
        $display("case2: same-cycle bypass then later write");

        for (int k = 0; k < 8; k++) begin
            drive(1, AW'(k), DW'(k * 3), 0, '0, 0);
            cycle();
        end
        oval_seen = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, '0, '0, 1, AW'(k), 0);
            cycle();
        end
        run_idle(4);
        chk("burst_oval_count", 64'(oval_seen), 64'd8);
        $display("case3: 8 back-to-back reads, %0d valid pulses", oval_seen);

        drive(0, '0, '0, 1, 32'h400, 0); cycle();
        run_idle(3);
        chk("oor_read_err", {62'd0, o_err}, 64'd1);
        drive(1, 32'h400, 32'hDEAD_BEEF, 0, '0, 0); cycle();
        drive(0, '0, '0, 1, 32'd0, 0); cycle();
        run_idle(4);
        $display("case4: out-of-range read and write");

        busy_seen = 0;
        drive(0, '0, '0, 0, '0, 1); cycle();
        drive(1, 32'd3, 32'h0000_BEEF, 0, '0, 0); cycle();
        drive(0, '0, '0, 1, 32'd4, 0); cycle();
        drive(0, '0, '0, 0, '0, 1); cycle();
        run_idle(DEPTH + 6);
        chk("clear_busy_cycles", 64'(busy_seen), 64'(DEPTH));
        chk("clear_err", {62'd0, o_err}, 64'd2);
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, '0, '0, 1, AW'(a), 0);
            cycle();
        end
        run_idle(4);
        $display("case5: clear with dropped requests, full readback");

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] wa, ra;
            wa = ($urandom_range(0, 19) == 0) ? AW'(32'h400 + $urandom_range(0, 3)) : AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 19) == 0) ? AW'(32'h400 + $urandom_range(0, 3)) : AW'($urandom_range(0, 15));
            drive(bit'($urandom_range(0, 1)), wa, DW'($urandom), bit'($urandom_range(0, 1)), ra, 0);
            cycle();
        end
        run_idle(4);
        $display("random: 400 cycles of mixed traffic");

        for (int k = 0; k < 4; k++) begin
            drive(0, '0, '0, 1, AW'(k), (k == 3));
            cycle();
        end
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_oval", {63'd0, bus.oval}, 64'd0);
        chk("midrst_busy", {63'd0, o_busy}, 64'd0);
        chk("midrst_err", {62'd0, o_err}, 64'd0);
        exp_q.delete();
        clr_left = 0;
        ref_err  = 2'b00;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        drive(0, '0, '0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 32'd9, 32'h0000_0055, 0, '0, 0); cycle();
        run_idle(1);
        drive(0, '0, '0, 1, 32'd9, 0); cycle();
        run_idle(4);
        $display("case6: reset mid-clear and mid-burst, then write/read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
